// File: rtl/divseq_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and
// the helper that sizes the iteration counter from the operand width.
package divseq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  function automatic int cnt_width(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if non-negative.
module divu_step #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] rem,
  input  logic          din,
  input  logic [DW:0]   dvs,
  output logic [DW-1:0] rem_nx,
  output logic          qbit
);

  logic [DW:0]   shifted;
  logic [DW+1:0] diff;
  logic          unused_diff_bit;

  // The kept remainder is always below |b| <= 2^(DW-1), so DW bits hold it.
  always_comb begin
    shifted = {rem, din};
    diff    = {1'b0, shifted} - {1'b0, dvs};
    qbit    = ~diff[DW+1];
    rem_nx  = qbit ? diff[DW-1:0] : shifted[DW-1:0];
  end

  assign unused_diff_bit = diff[DW];

endmodule

// File: rtl/divseq.sv
// Sequential signed divider: radix-2 restoring, one quotient bit per clock,
// start/busy/valid handshake with a fixed DW+1 cycle latency.
import divseq_pkg::*;

module divseq #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          valid,
  output logic [DW-1:0] q,
  output logic [DW-1:0] r,
  output logic          dbz,
  output logic [1:0]    dbg_state
);

  localparam int CW = cnt_width(DW);

  // Handshake: start is taken on any edge where busy=0 (including the valid
  // cycle); valid is a one-cycle pulse and q/r/dbz hold until the next result.
  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic [DW-1:0] dq;
  logic [DW-1:0] rem, rem_nx;
  logic [DW:0]   dvs, b_ext, b_mag;
  logic [DW-1:0] a_mag;
  logic          sign_r, sign_q, zero, qbit;

  assign a_mag     = a[DW-1] ? -a : a;
  assign b_ext     = {b[DW-1], b};
  assign b_mag     = b[DW-1] ? -b_ext : b_ext;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  divu_step #(.DW(DW)) u_step (
    .rem    (rem),
    .din    (dq[DW-1]),
    .dvs    (dvs),
    .rem_nx (rem_nx),
    .qbit   (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (count == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // dq starts as |a| and turns into |q| as quotient bits shift in from the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      dq     <= '0;
      rem    <= '0;
      dvs    <= '0;
      sign_r <= 1'b0;
      sign_q <= 1'b0;
      zero   <= 1'b0;
      valid  <= 1'b0;
      q      <= '0;
      r      <= '0;
      dbz    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dq     <= a_mag;
            rem    <= '0;
            dvs    <= b_mag;
            sign_r <= a[DW-1];
            sign_q <= a[DW-1] ^ b[DW-1];
            zero   <= (b == '0);
            count  <= CW'(DW - 1);
          end
        end
        CALC: begin
          rem <= rem_nx;
          dq  <= {dq[DW-2:0], qbit};
          if (count != '0) count <= count - 1'b1;
        end
        DONE: begin
          q     <= zero ? '1 : (sign_q ? -dq : dq);
          r     <= sign_r ? -rem : rem;
          dbz   <= zero;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divseq.sv
// Directed and table-driven checks of divseq: latency, signs, extremes,
// divide by zero, handshake corner cases, reset mid-operation, random sweep.
module tb_divseq;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a, b;
  logic          busy, valid, dbz;
  logic [DW-1:0] q, r;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
  } vec_t;

  vec_t vecs[14];

  divseq #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid     (valid),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                output logic [DW-1:0] eq, output logic [DW-1:0] er,
                                output logic ed);
    int xi, yi, qi, ri;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (yi == 0) begin
      eq = '1;
      er = x;
      ed = 1'b1;
    end else begin
      qi = xi / yi;
      ri = xi - qi * yi;
      eq = qi[DW-1:0];
      er = ri[DW-1:0];
      ed = 1'b0;
    end
  endfunction

  // Called #1 after an edge with the divider idle; returns #1 after the edge
  // that follows the valid cycle.
  task automatic run_op(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb_b,
                        input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic ed);
    int lat;
    int not_busy;
    a = ta;
    b = tb_b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom_range(0, 65535);
    b = $urandom_range(0, 65535);
    lat = 0;
    not_busy = 0;
    while (!valid && lat < 40) begin
      if (!busy) not_busy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd17);
    chk({name, "_busy_during"}, 64'(not_busy), 64'd0);
    chk({name, "_busy_at_valid"}, {63'd0, busy}, 64'd0);
    chk({name, "_q"}, 64'(q), 64'(eq));
    chk({name, "_r"}, 64'(r), 64'(er));
    chk({name, "_dbz"}, {63'd0, dbz}, {63'd0, ed});
    @(posedge clk); #1;
    chk({name, "_valid_pulse"}, {63'd0, valid}, 64'd0);
  endtask

  logic [DW-1:0] ha[54];
  logic [DW-1:0] hb[54];

  initial begin
    logic [DW-1:0] eq, er;
    logic          ed;
    int            stray;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    vecs[0]  = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
    vecs[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0};
    vecs[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0};
    vecs[3]  = '{16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0};
    vecs[4]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0};
    vecs[5]  = '{16'h8000, 16'd1,    16'h8000, 16'd0,    1'b0};
    vecs[6]  = '{16'd3,    16'd5,    16'd0,    16'd3,    1'b0};
    vecs[7]  = '{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1};
    vecs[8]  = '{16'd9,    16'd3,    16'd3,    16'd0,    1'b0};
    vecs[9]  = '{16'd0,    16'd7,    16'd0,    16'd0,    1'b0};
    vecs[10] = '{16'h8000, 16'd0,    16'hFFFF, 16'h8000, 1'b1};
    vecs[11] = '{16'h7FFF, 16'h8000, 16'd0,    16'h7FFF, 1'b0};
    vecs[12] = '{16'h8000, 16'h8000, 16'd1,    16'd0,    1'b0};
    vecs[13] = '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_q",     64'(q),         64'd0);
    chk("rst_r",     64'(r),         64'd0);
    chk("rst_dbz",   {63'd0, dbz},   64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // start held high: only edges 0, 18, 36 accept; results after edges 17, 35, 53.
    for (int c = 0; c < 54; c++) begin
      ha[c] = $urandom_range(0, 65535);
      hb[c] = $urandom_range(0, 65535);
    end
    for (int c = 0; c < 54; c++) begin
      a = ha[c];
      b = hb[c];
      start = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("held_valid_c%0d", c), {63'd0, valid}, {63'd0, (c % 18) == 17});
      if ((c % 18) == 17) begin
        model(ha[c-17], hb[c-17], eq, er, ed);
        chk($sformatf("held_q_c%0d", c), 64'(q), 64'(eq));
        chk($sformatf("held_r_c%0d", c), 64'(r), 64'(er));
        chk($sformatf("held_dbz_c%0d", c), {63'd0, dbz}, {63'd0, ed});
      end
    end
    start = 1'b0;
    @(posedge clk); #1;

    // start pulsed while busy must be ignored.
    a = 16'd1000; b = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a = 16'd7; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stray = 0;
    while (!valid && stray < 40) begin
      @(posedge clk); #1;
      stray++;
    end
    chk("ignore_latency", 64'(stray), 64'd11);
    chk("ignore_q", 64'(q), 64'd100);
    chk("ignore_r", 64'(r), 64'd0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid) stray++;
    end
    chk("ignore_no_second_valid", 64'(stray), 64'd0);

    // Reset five cycles into an operation: outputs clear at once, no result.
    a = 16'd100; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_q_before", 64'(q), 64'd100);
    rst = 1'b1;
    #1;
    chk("midrst_q",     64'(q),         64'd0);
    chk("midrst_r",     64'(r),         64'd0);
    chk("midrst_busy",  {63'd0, busy},  64'd0);
    chk("midrst_valid", {63'd0, valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid) stray++;
    end
    chk("midrst_no_valid", 64'(stray), 64'd0);
    run_op("after_rst", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      logic [DW-1:0] ra, rb;
      ra = $urandom_range(0, 65535);
      case (i % 8)
        0:       rb = '0;
        1:       rb = 16'hFFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom_range(0, 65535);
      endcase
      if (i % 16 == 3) ra = 16'h8000;
      model(ra, rb, eq, er, ed);
      run_op($sformatf("rand%0d", i), ra, rb, eq, er, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
